ifetch_queue: RTL and testbench

//   Instruction fetch stage directly upstream of the decode unit. Holds the fetch PC and issues
//   one-at-a-time word requests to the icache. Buffers returned instructions with their PCs in a

---
 rtl/ifetch_queue.sv | 138 +++++++++++++
 tb/tb_ifetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential PC+4 fetch through a one-outstanding icache request
// machine, with fetched {pc, inst} pairs buffered in a circular FIFO feeding dispatch.
module ifetch_queue #(
   parameter int QUEUE_SIZE_LOG = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        icache_req_valid,
   output logic [31:0] icache_req_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_inst,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        dispatch_ready,
   input  logic        flush,
   input  logic [31:0] flush_target
);

   localparam int DEPTH = 2 ** QUEUE_SIZE_LOG;
   localparam logic [QUEUE_SIZE_LOG:0]   CNT_FULL = (QUEUE_SIZE_LOG + 1)'(DEPTH);
   localparam logic [QUEUE_SIZE_LOG:0]   CNT_ONE  = (QUEUE_SIZE_LOG + 1)'(1);
   localparam logic [QUEUE_SIZE_LOG-1:0] PTR_ONE  = QUEUE_SIZE_LOG'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } state_e;

   state_e                    state_q, state_d;
   logic [31:0]               pc_q, pc_d;
   logic [QUEUE_SIZE_LOG-1:0] head_q, head_d;
   logic [QUEUE_SIZE_LOG-1:0] tail_q, tail_d;
   logic [QUEUE_SIZE_LOG:0]   count_q, count_d;
   logic                      req_valid_q, req_valid_d;
   logic [31:0]               req_addr_q, req_addr_d;
   logic                      push, pop;

   logic [31:0] inst_mem_q [DEPTH];
   logic [31:0] pc_mem_q   [DEPTH];

   assign inst_valid       = (count_q != '0);
   assign inst_out         = inst_mem_q[head_q];
   assign inst_pc          = pc_mem_q[head_q];
   // The strobe register may still be set in the cycle rdy drops; gate it so no request escapes.
   assign icache_req_valid = req_valid_q & rdy;
   assign icache_req_addr  = req_addr_q;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      req_valid_d = 1'b0;
      req_addr_d  = req_addr_q;
      push        = 1'b0;
      pop         = 1'b0;

      if (rdy) begin
         if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = {flush_target[31:2], 2'b00};
            unique case (state_q)
               ST_IDLE: state_d = ST_IDLE;
               ST_WAIT: state_d = icache_resp_valid ? ST_IDLE : ST_DROP;
               ST_DROP: state_d = icache_resp_valid ? ST_IDLE : ST_DROP;
               default: state_d = ST_IDLE;
            endcase
         end else begin
            pop = inst_valid && dispatch_ready;
            unique case (state_q)
               ST_IDLE: begin
                  if (count_q < CNT_FULL) begin
                     req_valid_d = 1'b1;
                     req_addr_d  = pc_q;
                     state_d     = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (icache_resp_valid) begin
                     push    = 1'b1;
                     pc_d    = pc_q + 32'd4;
                     state_d = ST_IDLE;
                  end
               end
               ST_DROP: begin
                  if (icache_resp_valid) state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase

            if (push) tail_d = tail_q + PTR_ONE;
            if (pop)  head_d = head_q + PTR_ONE;
            unique case ({push, pop})
               2'b10:   count_d = count_q + CNT_ONE;
               2'b01:   count_d = count_q - CNT_ONE;
               default: count_d = count_q;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
      end
   end

   // NOTE: FIFO storage is not reset; count gates validity, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[tail_q] <= icache_resp_inst;
         pc_mem_q[tail_q]   <= pc_q;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: cycle table for reset and first fetch, then hand sequences
// for fill, full stall, push+pop, drain, flush cases and rdy stall.
`timescale 1ns/1ps
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_inst;
   logic        inst_valid;
   logic [31:0] inst_out, inst_pc;
   logic        dispatch_ready, flush;
   logic [31:0] flush_target;

   int n_cmp  = 0;
   int n_fail = 0;

   ifetch_queue #(.QUEUE_SIZE_LOG(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .icache_req_valid (icache_req_valid),
      .icache_req_addr  (icache_req_addr),
      .icache_resp_valid(icache_resp_valid),
      .icache_resp_inst (icache_resp_inst),
      .inst_valid       (inst_valid),
      .inst_out         (inst_out),
      .inst_pc          (inst_pc),
      .dispatch_ready   (dispatch_ready),
      .flush            (flush),
      .flush_target     (flush_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        resp_valid;
      logic [31:0] resp_inst;
      logic        flush;
      logic [31:0] target;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request strobe and check its address.
   task automatic wait_req(input string name, input logic [31:0] addr);
      for (int i = 0; i < 20; i++) begin
         if (icache_req_valid) break;
         tick();
      end
      check({name, "_req_seen"}, {31'd0, icache_req_valid}, 32'd1);
      check({name, "_req_addr"}, icache_req_addr, addr);
   endtask

   // Called in the strobe cycle; responds two cycles later, optionally popping in that cycle.
   task automatic serve(input logic [31:0] inst, input logic pop_too);
      tick();
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_inst  = inst;
      dispatch_ready    = pop_too;
      tick();
      icache_resp_valid = 1'b0;
      icache_resp_inst  = '0;
      dispatch_ready    = 1'b0;
   endtask

   task automatic expect_no_req(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (icache_req_valid) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; icache_resp_valid = 1'b0; icache_resp_inst = '0;
      dispatch_ready = 1'b0; flush = 1'b0; flush_target = '0;

      //            rst rv  inst         fl  target        req addr   iv inst          pc
      vecs[0] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0,     32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,     32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h0, 1'b0, 32'h0,     32'h0};
      vecs[3] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,     32'h0};
      vecs[4] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,     32'h0};
      vecs[5] = '{1'b0, 1'b1, 32'h13,    1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 32'h13,    32'h0};
      vecs[6] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4, 1'b1, 32'h13,    32'h0};

      @(negedge clk);
      for (int v = 0; v < 7; v++) begin
         rst               = vecs[v].rst;
         icache_resp_valid = vecs[v].resp_valid;
         icache_resp_inst  = vecs[v].resp_inst;
         flush             = vecs[v].flush;
         flush_target      = vecs[v].target;
         tick();
         check($sformatf("vec%0d_req", v), {31'd0, icache_req_valid}, {31'd0, vecs[v].exp_req});
         check($sformatf("vec%0d_addr", v), icache_req_addr, vecs[v].exp_addr);
         check($sformatf("vec%0d_iv", v), {31'd0, inst_valid}, {31'd0, vecs[v].exp_iv});
         if (vecs[v].exp_iv) begin
            check($sformatf("vec%0d_inst", v), inst_out, vecs[v].exp_inst);
            check($sformatf("vec%0d_pc", v), inst_pc, vecs[v].exp_pc);
         end
      end
      icache_resp_valid = 1'b0; flush = 1'b0; flush_target = '0;

      // Fill the queue: request for 0x4 is already on the bus.
      for (int n = 1; n < 16; n++) begin
         wait_req($sformatf("fill%0d", n), 32'(4 * n));
         serve(32'h13 + 32'(n), 1'b0);
      end
      expect_no_req("full_no_req", 10);
      check("full_head_inst", inst_out, 32'h13);
      check("full_head_pc", inst_pc, 32'h0);

      // Single pop from full, then fetch resumes at 0x40.
      dispatch_ready = 1'b1;
      tick();
      dispatch_ready = 1'b0;
      check("pop1_inst", inst_out, 32'h14);
      check("pop1_pc", inst_pc, 32'h4);
      wait_req("after_pop", 32'h40);
      serve(32'h23, 1'b1);
      check("pushpop_inst", inst_out, 32'h15);
      check("pushpop_pc", inst_pc, 32'h8);
      wait_req("after_pushpop", 32'h44);
      serve(32'h24, 1'b0);
      expect_no_req("refull_no_req", 10);

      // Drain all 16 entries, crossing the pointer wrap.
      dispatch_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain%0d_iv", i), {31'd0, inst_valid}, 32'd1);
         check($sformatf("drain%0d_pc", i), inst_pc, 32'h8 + 32'(4 * i));
         check($sformatf("drain%0d_inst", i), inst_out, 32'h15 + 32'(i));
         tick();
      end
      check("drained_iv", {31'd0, inst_valid}, 32'd0);
      tick();
      check("pop_empty_iv", {31'd0, inst_valid}, 32'd0);
      dispatch_ready = 1'b0;

      // Flush while a request (0x48) is outstanding; its response must be dropped.
      flush = 1'b1; flush_target = 32'h1003;
      tick();
      flush = 1'b0; flush_target = '0;
      check("flushwait_req", {31'd0, icache_req_valid}, 32'd0);
      check("flushwait_iv", {31'd0, inst_valid}, 32'd0);
      icache_resp_valid = 1'b1; icache_resp_inst = 32'hDEAD;
      tick();
      icache_resp_valid = 1'b0;
      check("drop_iv", {31'd0, inst_valid}, 32'd0);
      check("drop_no_req", {31'd0, icache_req_valid}, 32'd0);
      tick();
      check("redirect_req", {31'd0, icache_req_valid}, 32'd1);
      check("redirect_addr", icache_req_addr, 32'h1000);

      // Flush coinciding with the response.
      tick();
      icache_resp_valid = 1'b1; icache_resp_inst = 32'hBAD;
      flush = 1'b1; flush_target = 32'h2000;
      tick();
      icache_resp_valid = 1'b0; flush = 1'b0; flush_target = '0;
      check("flushresp_iv", {31'd0, inst_valid}, 32'd0);
      check("flushresp_req", {31'd0, icache_req_valid}, 32'd0);
      tick();
      check("flushresp_next_req", {31'd0, icache_req_valid}, 32'd1);
      check("flushresp_next_addr", icache_req_addr, 32'h2000);

      // Flush in IDLE with a queued entry clears the queue and suppresses the strobe that cycle.
      serve(32'hA0, 1'b0);
      check("idle_pre_iv", {31'd0, inst_valid}, 32'd1);
      check("idle_pre_pc", inst_pc, 32'h2000);
      flush = 1'b1; flush_target = 32'h3000;
      tick();
      flush = 1'b0; flush_target = '0;
      check("idleflush_req", {31'd0, icache_req_valid}, 32'd0);
      check("idleflush_iv", {31'd0, inst_valid}, 32'd0);
      tick();
      check("idleflush_next_addr", icache_req_addr, 32'h3000);
      check("idleflush_next_req", {31'd0, icache_req_valid}, 32'd1);

      // rdy low mid-WAIT: nothing moves, pops suppressed.
      serve(32'hB0, 1'b0);
      wait_req("pre_stall", 32'h3004);
      tick();
      rdy = 1'b0; dispatch_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("stall%0d_req", i), {31'd0, icache_req_valid}, 32'd0);
         check($sformatf("stall%0d_addr", i), icache_req_addr, 32'h3004);
         check($sformatf("stall%0d_iv", i), {31'd0, inst_valid}, 32'd1);
         check($sformatf("stall%0d_pc", i), inst_pc, 32'h3000);
      end
      rdy = 1'b1; dispatch_ready = 1'b0;
      icache_resp_valid = 1'b1; icache_resp_inst = 32'hB4;
      tick();
      icache_resp_valid = 1'b0;
      check("resume_pc", inst_pc, 32'h3000);
      check("resume_inst", inst_out, 32'hB0);
      wait_req("resume", 32'h3008);
      dispatch_ready = 1'b1;
      tick();
      dispatch_ready = 1'b0;
      check("resume_pop_pc", inst_pc, 32'h3004);
      check("resume_pop_inst", inst_out, 32'hB4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
